// File: rtl/cube_frame_loader_if.sv
// Byte-stream handshake into the cube frame loader.
// A byte transfers on a rising clock edge where in_valid and in_ready are both high.
interface cube_frame_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cube_frame_loader.sv
// Write side of the LED-cube frame buffer: assembles SYNC + 64 data + XOR checksum packets
// into a back buffer and commits them whole to the front buffer only when the checksum matches.
module cube_frame_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    cube_frame_loader_if.slave    in_if,
    output logic [511:0]          frame_cube_flat,
    output logic                  frame_swap,
    output logic                  err_chk,
    output logic                  err_timeout
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT, DATA, CHECK, COMMIT} state_t;

    state_t         state;
    logic [511:0]   back;
    logic [5:0]     idx;
    logic [7:0]     xacc;
    logic [TW-1:0]  tcnt;
    logic           accept;
    logic           timeout_hit;

    assign in_if.in_ready = (state != COMMIT);
    assign accept         = in_if.in_valid & in_if.in_ready;
    // Fires on the TIMEOUT-th idle edge after the last accepted byte; an accept on that edge wins.
    assign timeout_hit    = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= HUNT;
            back            <= '0;
            idx             <= '0;
            xacc            <= '0;
            tcnt            <= '0;
            frame_cube_flat <= '0;
            frame_swap      <= 1'b0;
            err_chk         <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            frame_swap  <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                HUNT: begin
                    if (accept && in_if.in_data == SYNC_BYTE) begin
                        idx   <= '0;
                        xacc  <= '0;
                        tcnt  <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        back[{idx, 3'b000} +: 8] <= in_if.in_data;
                        xacc <= xacc ^ in_if.in_data;
                        tcnt <= '0;
                        idx  <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            state <= CHECK;
                        end
                    end else if (timeout_hit) begin
                        tcnt        <= '0;
                        err_timeout <= 1'b1;
                        state       <= HUNT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CHECK: begin
                    if (accept) begin
                        tcnt <= '0;
                        if (in_if.in_data == xacc) begin
                            state <= COMMIT;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= HUNT;
                        end
                    end else if (timeout_hit) begin
                        tcnt        <= '0;
                        err_timeout <= 1'b1;
                        state       <= HUNT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                COMMIT: begin
                    frame_cube_flat <= back;
                    frame_swap      <= 1'b1;
                    state           <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
